status_poller: RTL and testbench
================================

# status_poller

Host-side initiator for the motor-board RS485 status protocol. On request it sends a 7-byte status-request frame (magic `0x1CE1CEBB`, ID, CRC16) to one motor board, then receives and checks that board's 28-byte status frame (magic `0x1CEB00DA`). The decoded fields are presented as registered outputs. It sits between the host control logic and a byte-level UART pair, and is the counterpart of the motor board's frame matcher.

## Interface
- `CLK_FREQ_HZ`, 16_000_000: clock frequency. Informational only; passed to the UART wrappers.
- `TIMEOUT_CYCLES`, 160_000: maximum number of cycles between the last request byte leaving and the final status byte arriving.
- `CLK` in 1: system clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous reset, active-low.
- `poll_start` in 1: one-cycle strobe that starts a poll. Ignored while `busy`=1.
- `poll_id` in 8: target board ID. Sampled when `poll_start` is accepted.
- `tx_start` out 1: one-cycle strobe that hands `tx_data` to the UART transmitter.
- `tx_data` out 8: byte to transmit.
- `tx_busy` in 1: UART transmitter active. Must go high the cycle after `tx_start`.
- `rx_valid` in 1: one-cycle strobe, a received byte is on `rx_data`.
- `rx_data` in 8: received byte.
- `driver_enable` out 1: RS485 driver enable. High from acceptance of `poll_start` until the last request byte completes.
- `busy` out 1: a poll is in progress.
- `done` out 1: one-cycle strobe marking the end of a poll, whatever the outcome.
- `resp_valid`, `err_crc`, `err_id`, `err_timeout` out 1 each: outcome flags. Each is valid only in the cycle `done`=1, and exactly one of them is high.
- `control_mode` out 8: status field.
- `encoder0_position`, `encoder1_position`, `setpoint`, `duty`, `displacement` out 24 each, signed: status fields.
- `current` out 16, signed: status field.

## Operation
- Reset: all outputs 0, state IDLE, CRC register `0xFFFF`, magic shift register 0.
- CRC: CRC16, polynomial x^16+x^15+x^2+1, initial value `0xFFFF`, byte-serial, data bit 7 fed first. The high byte is transmitted first.
- Request frame: `1C E1 CE BB`, ID, CRC[15:8], CRC[7:0]. The CRC covers the ID byte only.
- Status frame byte layout:
  - 0–3: magic.
  - 4: ID.
  - 5: control_mode.
  - 6–8: enc0.
  - 9–11: enc1.
  - 12–14: setpoint.
  - 15–17: duty.
  - 18–20: displacement.
  - 21–22: current.
  - 23–25: pad (ignored, but included in the CRC).
  - 26–27: CRC over bytes 4..25.
  - All multi-byte fields are MSB first.
- States:
  - IDLE: wait for `poll_start`. On acceptance, latch `poll_id`, set byte index 0, go to SEND.
  - SEND: when `tx_busy`=0 and `tx_start` was 0 in the previous cycle, pulse `tx_start` with byte[index] and increment the index. Once byte 6 has been issued and `tx_busy` has fallen, drop `driver_enable`, clear the timeout counter and the magic shift register, and go to HUNT.
  - HUNT: on each `rx_valid`, shift the byte into the 4-byte register. When the register holds `1CEB00DA`, go to BODY with counter 0 and CRC `0xFFFF`.
  - BODY: on each `rx_valid`, store byte `counter+4`. Update the CRC for bytes 4..25 only. After byte 27, go to CHECK.
  - CHECK: takes one cycle.
    - CRC mismatch: `err_crc`.
    - CRC good but byte 4 ≠ latched ID: `err_id`.
    - Otherwise: load all status outputs and set `resp_valid`.
    - In every case pulse `done` and return to IDLE.
- Timeout:
  - The counter runs in HUNT and BODY.
  - When it reaches `TIMEOUT_CYCLES-1`, pulse `done` with `err_timeout` and return to IDLE.
  - The status outputs are left unchanged.
- Status outputs change only on `resp_valid`. A failed poll keeps the previous values.
- `rx_valid` is ignored in IDLE, SEND and CHECK. This means the host's own RS485 echo during SEND is discarded.
- Simultaneous events: if the final byte of BODY arrives on the timeout cycle, the byte wins and the block goes to CHECK.
- Reset asserted mid-poll aborts immediately to the reset state. No `done` is produced.

## Timing
- The first `tx_start` comes 1 cycle after `poll_start` is accepted.
- Consecutive `tx_start` pulses are at least 2 cycles apart and gated by `tx_busy`.
- `done` comes exactly 1 cycle after the `rx_valid` of byte 27. The status outputs update in that same cycle.
- `busy` goes high the cycle after `poll_start` and low the cycle after `done`.
- Back-to-back polls: a `poll_start` in the cycle after `done` is accepted.

## Test plan
- Nominal poll:
  - Stimulus: ID `0x05`, `tx_busy` model of 10 cycles per byte, reference-model reply with enc0 `0x000123`, enc1 `0xFFFFFE`, current `0x8001`.
  - Required: 7 tx bytes `1C E1 CE BB 05 crcH crcL`; `resp_valid`=1; enc0=291, enc1=−2, current=−32767.
- Corrupt CRC: same reply with byte 27 XOR `0x01` → `done`+`err_crc`; outputs keep the previous values.
- Wrong board: reply from ID `0x06` with a valid CRC → `err_id`; no output change.
- Magic hunting: 3 junk bytes `1C EB 00` then a valid frame → the frame is accepted, because hunting resynchronises on the overlapping prefix.
- Timeout: no reply, `TIMEOUT_CYCLES`=1000 → `err_timeout` exactly 1000 cycles after entering HUNT. A partial frame (10 bytes) followed by silence also times out.
- Reset mid-BODY: `reset_n` low for 1 cycle after byte 15 → all outputs 0, IDLE. A subsequent poll then succeeds normally.

Source files
------------

// File: rtl/status_poller_if.sv
`default_nettype none
// ============================================================================
//  Module   : status_poller_if
//  Brief    : Byte-level UART / RS485 link between the status poller and the
//             UART transmitter/receiver pair.
//  Revision : 1.0 - initial release
// ============================================================================
interface status_poller_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       driver_enable;

    modport master (
        output tx_start,
        output tx_data,
        output driver_enable,
        input  tx_busy,
        input  rx_valid,
        input  rx_data
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        input  driver_enable,
        output tx_busy,
        output rx_valid,
        output rx_data
    );
endinterface
`default_nettype wire

// File: rtl/status_poller.sv
`default_nettype none
// ============================================================================
//  Module   : status_poller
//  Brief    : Sends a status-request frame to one motor board over RS485 and
//             receives, checks and decodes its 28-byte status frame.
//  Revision : 1.0 - initial release
// ============================================================================
module status_poller #(
    parameter int CLK_FREQ_HZ    = 16_000_000,
    parameter int TIMEOUT_CYCLES = 160_000
) (
    input  wire                CLK,
    input  wire                reset_n,
    input  wire                poll_start,
    input  wire         [7:0]  poll_id,
    status_poller_if.master    uart,
    output logic               busy,
    output logic               done,
    output logic               resp_valid,
    output logic               err_crc,
    output logic               err_id,
    output logic               err_timeout,
    output logic        [7:0]  control_mode,
    output logic signed [23:0] encoder0_position,
    output logic signed [23:0] encoder1_position,
    output logic signed [23:0] setpoint,
    output logic signed [23:0] duty,
    output logic signed [23:0] displacement,
    output logic signed [15:0] current
);

    localparam int                 c_CNT_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST   = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]        c_MAGIC_RESP = 32'h1CEB00DA;
    localparam logic [15:0]        c_CRC_INIT   = 16'hFFFF;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SEND  = 3'd1;
    localparam logic [2:0] c_HUNT  = 3'd2;
    localparam logic [2:0] c_BODY  = 3'd3;
    localparam logic [2:0] c_CHECK = 3'd4;

    generate
        if (TIMEOUT_CYCLES < 2 || CLK_FREQ_HZ < 1) begin : g_param_check
            $error("status_poller: TIMEOUT_CYCLES must be >= 2 and CLK_FREQ_HZ positive");
        end
    endgenerate

    // CRC16 0x8005, MSB-first, one byte per call
    function automatic logic [15:0] f_crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h8005;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [2:0]         r_state;
    logic [7:0]         r_id;
    logic [2:0]         r_tx_idx;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic               r_drv_en;
    logic [c_CNT_W-1:0] r_tcnt;
    logic [31:0]        r_magic;
    logic [4:0]         r_body_cnt;
    logic [15:0]        r_crc;
    logic [183:0]       r_body;
    logic               r_done;
    logic               r_resp_valid;
    logic               r_err_crc;
    logic               r_err_id;
    logic               r_err_timeout;
    logic [7:0]         r_control_mode;
    logic [23:0]        r_enc0;
    logic [23:0]        r_enc1;
    logic [23:0]        r_setpoint;
    logic [23:0]        r_duty;
    logic [23:0]        r_displacement;
    logic [15:0]        r_current;

    logic [15:0]        w_req_crc;
    logic [7:0]         w_req_byte;
    logic [31:0]        w_magic_next;
    logic [191:0]       w_frame;
    logic [15:0]        w_rx_crc;
    logic               w_timeout;
    logic               w_last_byte;
    logic               w_unused_pad;

    assign w_req_crc    = f_crc16_byte(c_CRC_INIT, r_id);
    assign w_magic_next = {r_magic[23:0], uart.rx_data};
    // Bytes 4..27 of the status frame, byte 4 in the top bits, as seen on the final byte's edge
    assign w_frame      = {r_body, uart.rx_data};
    assign w_rx_crc     = w_frame[15:0];
    assign w_unused_pad = ^w_frame[39:16];
    assign w_timeout    = (r_tcnt == c_TMO_LAST);
    assign w_last_byte  = uart.rx_valid && (r_body_cnt == 5'd23);

    always_comb begin
        w_req_byte = 8'h1C;
        case (r_tx_idx)
            3'd1:    w_req_byte = 8'hE1;
            3'd2:    w_req_byte = 8'hCE;
            3'd3:    w_req_byte = 8'hBB;
            3'd4:    w_req_byte = r_id;
            3'd5:    w_req_byte = w_req_crc[15:8];
            3'd6:    w_req_byte = w_req_crc[7:0];
            default: w_req_byte = 8'h1C;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= c_IDLE;
            r_id           <= 8'h00;
            r_tx_idx       <= 3'd0;
            r_tx_start     <= 1'b0;
            r_tx_data      <= 8'h00;
            r_drv_en       <= 1'b0;
            r_tcnt         <= '0;
            r_magic        <= 32'h0;
            r_body_cnt     <= 5'd0;
            r_crc          <= c_CRC_INIT;
            r_body         <= '0;
            r_done         <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_err_crc      <= 1'b0;
            r_err_id       <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_control_mode <= 8'h00;
            r_enc0         <= 24'h0;
            r_enc1         <= 24'h0;
            r_setpoint     <= 24'h0;
            r_duty         <= 24'h0;
            r_displacement <= 24'h0;
            r_current      <= 16'h0;
        end else begin
            r_tx_start    <= 1'b0;
            r_done        <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_err_crc     <= 1'b0;
            r_err_id      <= 1'b0;
            r_err_timeout <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    // Byte 0 goes out on the acceptance edge so tx_start follows poll_start by one cycle
                    if (poll_start) begin
                        r_id       <= poll_id;
                        r_tx_start <= 1'b1;
                        r_tx_data  <= 8'h1C;
                        r_tx_idx   <= 3'd1;
                        r_drv_en   <= 1'b1;
                        r_state    <= c_SEND;
                    end
                end

                c_SEND: begin
                    if (!uart.tx_busy && !r_tx_start) begin
                        if (r_tx_idx == 3'd7) begin
                            r_drv_en <= 1'b0;
                            r_tcnt   <= '0;
                            r_magic  <= 32'h0;
                            r_state  <= c_HUNT;
                        end else begin
                            r_tx_start <= 1'b1;
                            r_tx_data  <= w_req_byte;
                            r_tx_idx   <= r_tx_idx + 3'd1;
                        end
                    end
                end

                c_HUNT: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (w_timeout) begin
                        r_done        <= 1'b1;
                        r_err_timeout <= 1'b1;
                        r_state       <= c_CHECK;
                    end else if (uart.rx_valid) begin
                        r_magic <= w_magic_next;
                        if (w_magic_next == c_MAGIC_RESP) begin
                            r_body_cnt <= 5'd0;
                            r_crc      <= c_CRC_INIT;
                            r_state    <= c_BODY;
                        end
                    end
                end

                c_BODY: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    // The final byte beats a coincident timeout
                    if (w_last_byte) begin
                        r_done  <= 1'b1;
                        r_state <= c_CHECK;
                        if (w_rx_crc != r_crc) begin
                            r_err_crc <= 1'b1;
                        end else if (w_frame[191:184] != r_id) begin
                            r_err_id <= 1'b1;
                        end else begin
                            r_resp_valid   <= 1'b1;
                            r_control_mode <= w_frame[183:176];
                            r_enc0         <= w_frame[175:152];
                            r_enc1         <= w_frame[151:128];
                            r_setpoint     <= w_frame[127:104];
                            r_duty         <= w_frame[103:80];
                            r_displacement <= w_frame[79:56];
                            r_current      <= w_frame[55:40];
                        end
                    end else if (w_timeout) begin
                        r_done        <= 1'b1;
                        r_err_timeout <= 1'b1;
                        r_state       <= c_CHECK;
                    end else if (uart.rx_valid) begin
                        r_body     <= {r_body[175:0], uart.rx_data};
                        r_body_cnt <= r_body_cnt + 5'd1;
                        if (r_body_cnt < 5'd22) begin
                            r_crc <= f_crc16_byte(r_crc, uart.rx_data);
                        end
                    end
                end

                c_CHECK: begin
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign uart.tx_start      = r_tx_start;
    assign uart.tx_data       = r_tx_data;
    assign uart.driver_enable = r_drv_en;

    assign busy              = (r_state != c_IDLE);
    assign done              = r_done;
    assign resp_valid        = r_resp_valid;
    assign err_crc           = r_err_crc;
    assign err_id            = r_err_id;
    assign err_timeout       = r_err_timeout;
    assign control_mode      = r_control_mode;
    assign encoder0_position = r_enc0;
    assign encoder1_position = r_enc1;
    assign setpoint          = r_setpoint;
    assign duty              = r_duty;
    assign displacement      = r_displacement;
    assign current           = r_current;

endmodule
`default_nettype wire

// File: tb/tb_status_poller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_status_poller
//  Brief    : Self-checking bench for status_poller with a frame-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_status_poller;

    localparam int c_TIMEOUT = 1000;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic [7:0]  id;
        logic [7:0]  cm;
        logic [23:0] e0;
        logic [23:0] e1;
        logic [23:0] sp;
        logic [23:0] du;
        logic [23:0] dp;
        logic [15:0] cur;
    } status_t;

    logic               clk;
    logic               reset_n;
    logic               poll_start;
    logic [7:0]         poll_id;
    logic               busy, done, resp_valid, err_crc, err_id, err_timeout;
    logic [7:0]         control_mode;
    logic signed [23:0] encoder0_position, encoder1_position, setpoint, duty, displacement;
    logic signed [15:0] current;

    status_poller_if u_if ();

    status_poller #(
        .CLK_FREQ_HZ   (16_000_000),
        .TIMEOUT_CYCLES(c_TIMEOUT)
    ) u_dut (
        .CLK              (clk),
        .reset_n          (reset_n),
        .poll_start       (poll_start),
        .poll_id          (poll_id),
        .uart             (u_if),
        .busy             (busy),
        .done             (done),
        .resp_valid       (resp_valid),
        .err_crc          (err_crc),
        .err_id           (err_id),
        .err_timeout      (err_timeout),
        .control_mode     (control_mode),
        .encoder0_position(encoder0_position),
        .encoder1_position(encoder1_position),
        .setpoint         (setpoint),
        .duty             (duty),
        .displacement     (displacement),
        .current          (current)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic [7:0]  tx_q [$];
    int          tx_time [$];
    status_t     exp_st;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART transmitter model: busy for 10 cycles starting the cycle after tx_start
    initial begin
        int bcnt;
        bcnt = 0;
        u_if.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bcnt > 0) begin
                u_if.tx_busy = 1'b1;
                bcnt--;
            end else begin
                u_if.tx_busy = 1'b0;
            end
            if (u_if.tx_start) begin
                tx_q.push_back(u_if.tx_data);
                tx_time.push_back(cyc);
                bcnt = 10;
            end
        end
    end

    // Outcome flags are one-hot on done, busy drops the cycle after
    initial begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (prev_done) check("busy_after_done", busy, 0);
            if (done) check("done_onehot", $countones({resp_valid, err_crc, err_id, err_timeout}), 1);
            prev_done = done;
        end
    end

    // CRC as polynomial long division: remainder of (init*x^n + M*x^16) mod 0x18005
    function automatic logic [15:0] ref_crc(input byte_q_t msg);
        bit          bits [$];
        logic [16:0] gen;
        logic [15:0] r;
        int          n;
        gen = 17'h18005;
        n   = msg.size() * 8;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) bits.push_back(msg[i][b]);
        end
        for (int i = 0; i < 16; i++) bits.push_back(1'b0);
        for (int i = 0; i < 16; i++) bits[i] = bits[i] ^ 1'b1;
        for (int i = 0; i < n; i++) begin
            if (bits[i]) begin
                for (int k = 0; k < 17; k++) bits[i+k] = bits[i+k] ^ gen[16-k];
            end
        end
        for (int i = 0; i < 16; i++) r[15-i] = bits[n+i];
        return r;
    endfunction

    function automatic byte_q_t build_frame(input status_t s);
        byte_q_t     f;
        byte_q_t     body;
        logic [15:0] c;
        f.push_back(8'h1C); f.push_back(8'hEB); f.push_back(8'h00); f.push_back(8'hDA);
        body.push_back(s.id);
        body.push_back(s.cm);
        body.push_back(s.e0[23:16]); body.push_back(s.e0[15:8]); body.push_back(s.e0[7:0]);
        body.push_back(s.e1[23:16]); body.push_back(s.e1[15:8]); body.push_back(s.e1[7:0]);
        body.push_back(s.sp[23:16]); body.push_back(s.sp[15:8]); body.push_back(s.sp[7:0]);
        body.push_back(s.du[23:16]); body.push_back(s.du[15:8]); body.push_back(s.du[7:0]);
        body.push_back(s.dp[23:16]); body.push_back(s.dp[15:8]); body.push_back(s.dp[7:0]);
        body.push_back(s.cur[15:8]); body.push_back(s.cur[7:0]);
        for (int i = 0; i < 3; i++) body.push_back(8'($urandom_range(255, 0)));
        c = ref_crc(body);
        foreach (body[i]) f.push_back(body[i]);
        f.push_back(c[15:8]);
        f.push_back(c[7:0]);
        return f;
    endfunction

    task automatic rand_status(input logic [7:0] id, output status_t s);
        s.id  = id;
        s.cm  = 8'($urandom);
        s.e0  = 24'($urandom);
        s.e1  = 24'($urandom);
        s.sp  = 24'($urandom);
        s.du  = 24'($urandom);
        s.dp  = 24'($urandom);
        s.cur = 16'($urandom);
    endtask

    task automatic clear_exp();
        exp_st.id = 8'h0;  exp_st.cm = 8'h0;  exp_st.e0 = 24'h0; exp_st.e1 = 24'h0;
        exp_st.sp = 24'h0; exp_st.du = 24'h0; exp_st.dp = 24'h0; exp_st.cur = 16'h0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_cm"},   {24'd0, control_mode},      {24'd0, exp_st.cm});
        check({tag, "_enc0"}, {8'd0, encoder0_position},  {8'd0, exp_st.e0});
        check({tag, "_enc1"}, {8'd0, encoder1_position},  {8'd0, exp_st.e1});
        check({tag, "_sp"},   {8'd0, setpoint},           {8'd0, exp_st.sp});
        check({tag, "_duty"}, {8'd0, duty},               {8'd0, exp_st.du});
        check({tag, "_disp"}, {8'd0, displacement},       {8'd0, exp_st.dp});
        check({tag, "_cur"},  {16'd0, current},           {16'd0, exp_st.cur});
    endtask

    // Issues poll_start the next cycle, checks the request frame, returns the first HUNT cycle
    task automatic start_poll(input logic [7:0] id, output int hunt_cyc);
        byte_q_t     idq;
        logic [15:0] rc;
        logic [7:0]  req [7];
        int          acc, t;
        bit          gap_ok;
        idq.push_back(id);
        rc  = ref_crc(idq);
        req = '{8'h1C, 8'hE1, 8'hCE, 8'hBB, id, rc[15:8], rc[7:0]};
        @(posedge clk);
        #1;
        tx_q.delete();
        tx_time.delete();
        poll_id    = id;
        poll_start = 1'b1;
        acc        = cyc;
        @(posedge clk);
        #1;
        poll_start = 1'b0;
        check("busy_rise", busy, 1);
        t = 0;
        while ((u_if.driver_enable || tx_q.size() < 7) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("send_in_time", (t < 300), 1);
        hunt_cyc = cyc;
        check("tx_count", tx_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < tx_q.size()) check($sformatf("tx_byte%0d", i), tx_q[i], req[i]);
        end
        if (tx_time.size() > 0) check("tx_first_latency", tx_time[0] - acc, 1);
        gap_ok = 1'b1;
        for (int i = 1; i < tx_time.size(); i++) begin
            if (tx_time[i] - tx_time[i-1] < 2) gap_ok = 1'b0;
        end
        check("tx_spacing", gap_ok, 1);
    endtask

    task automatic send_bytes(input byte_q_t b, input int gap_max, output int rx_last);
        int g;
        rx_last = cyc;
        foreach (b[i]) begin
            u_if.rx_valid = 1'b1;
            u_if.rx_data  = b[i];
            rx_last       = cyc;
            @(posedge clk);
            #1;
            u_if.rx_valid = 1'b0;
            if (i != b.size() - 1) begin
                g = $urandom_range(gap_max, 0);
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_done(input int bound, output logic [3:0] flags, output int d_cyc);
        int t;
        t = 0;
        while (!done && t < bound) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("done_seen", done, 1);
        flags = {resp_valid, err_crc, err_id, err_timeout};
        d_cyc = cyc;
    endtask

    // One full poll with a reply; outcome predicted from the frame contents
    task automatic poll_with_reply(input string tag, input logic [7:0] id, input status_t s,
                                   input int kind);
        byte_q_t    fr;
        logic [3:0] flags, exp_flags;
        int         h, rx_last, d_cyc;
        fr = build_frame(s);
        if (kind == 1) fr[27] = fr[27] ^ 8'($urandom_range(255, 1));
        if (kind == 3) begin
            fr.push_front(8'h00);
            fr.push_front(8'hEB);
            fr.push_front(8'h1C);
        end
        start_poll(id, h);
        send_bytes(fr, 2, rx_last);
        wait_done(c_TIMEOUT + 100, flags, d_cyc);
        if (kind == 1)          exp_flags = 4'b0100;
        else if (s.id != id)    exp_flags = 4'b0010;
        else                    exp_flags = 4'b1000;
        check({tag, "_flags"}, {28'd0, flags}, {28'd0, exp_flags});
        check({tag, "_done_latency"}, d_cyc - rx_last, 1);
        if (exp_flags == 4'b1000) exp_st = s;
        check_outputs(tag);
    endtask

    initial begin
        status_t    s;
        logic [3:0] flags;
        int         h, rx_last, d_cyc, v, ndone, kind;
        logic [7:0] id;
        byte_q_t    fr, part;

        reset_n       = 1'b0;
        poll_start    = 1'b0;
        poll_id       = 8'h00;
        u_if.rx_valid = 1'b0;
        u_if.rx_data  = 8'h00;
        clear_exp();

        @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_start", u_if.tx_start, 0);
        check("rst_drv_en", u_if.driver_enable, 0);
        check("rst_resp_valid", resp_valid, 0);
        check_outputs("rst");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Nominal poll with the signed corner values
        rand_status(8'h05, s);
        s.e0  = 24'h000123;
        s.e1  = 24'hFFFFFE;
        s.cur = 16'h8001;
        poll_with_reply("nominal", 8'h05, s, 0);
        v = encoder0_position;
        check("nominal_enc0_dec", v, 291);
        v = encoder1_position;
        check("nominal_enc1_dec", v, -2);
        v = current;
        check("nominal_cur_dec", v, -32767);

        poll_with_reply("bad_crc", 8'h05, s, 1);

        rand_status(8'h06, s);
        poll_with_reply("wrong_id", 8'h05, s, 0);

        rand_status(8'h05, s);
        poll_with_reply("hunt", 8'h05, s, 3);

        // Silence: err_timeout exactly TIMEOUT cycles after entering HUNT
        start_poll(8'h21, h);
        wait_done(c_TIMEOUT + 100, flags, d_cyc);
        check("to_flags", {28'd0, flags}, 32'h1);
        check("to_latency", d_cyc - h, c_TIMEOUT);
        check_outputs("to");

        // Partial frame then silence
        rand_status(8'h22, s);
        fr = build_frame(s);
        part = fr[0:9];
        start_poll(8'h22, h);
        send_bytes(part, 3, rx_last);
        wait_done(c_TIMEOUT + 100, flags, d_cyc);
        check("partial_flags", {28'd0, flags}, 32'h1);
        check("partial_latency", d_cyc - h, c_TIMEOUT);
        check_outputs("partial");

        // Reset after byte 15 of the body
        rand_status(8'h33, s);
        fr = build_frame(s);
        part = fr[0:15];
        start_poll(8'h33, h);
        send_bytes(part, 1, rx_last);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        clear_exp();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_drv_en", u_if.driver_enable, 0);
        check("mid_rst_tx_data", u_if.tx_data, 0);
        check_outputs("mid_rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ndone = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("mid_rst_no_done", ndone, 0);
        rand_status(8'h33, s);
        poll_with_reply("after_rst", 8'h33, s, 0);

        // Randomised polls, each started the cycle after the previous done
        for (int n = 0; n < 8; n++) begin
            kind = $urandom_range(3, 0);
            id   = 8'($urandom);
            if (kind == 2) rand_status(id ^ 8'($urandom_range(255, 1)), s);
            else           rand_status(id, s);
            poll_with_reply($sformatf("rnd%0d", n), id, s, kind);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
